uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter between N byte-stream requesters using round-robin arbitration with packet hold.
- Once granted, a requester keeps the transmitter until it presents a byte with req_last set, or until its hold timeout expires.
- An optional per-packet header byte identifies the source channel to the far end.
- Sits between client logic and uart_tx; drives tx_start/tx_din and consumes tx_done_tick.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_arbiter_rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encodings, defaults and a
// constant clog2 helper used to size ports and counters.
package uart_pkg;

  localparam int unsigned DBIT_DEF     = 8;
  localparam int unsigned SB_TICK_DEF  = 16;
  localparam logic [7:0]  HDR_BASE_DEF = 8'hA0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    HDR  = S_HDR,
    SEND = S_SEND,
    WAIT = S_WAIT,
    HOLD = S_HOLD
  } arb_state_t;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or after rr_ptr_i,
// wrapping modulo N with an explicit compare so non-power-of-2 N is safe.
module rr_picker
  import uart_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req_valid_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          found_c_o,
  output logic [IW-1:0] index_c_o
);

  int unsigned idx;

  always_comb begin
    found_c_o = 1'b0;
    index_c_o = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found_c_o && req_valid_i[IW'(idx)]) begin
        found_c_o = 1'b1;
        index_c_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N byte-stream requesters, with
// packet hold, optional per-packet channel header and mid-packet idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned     N            = 4,
  parameter  int unsigned     DBIT         = DBIT_DEF,
  parameter  bit              HDR_EN       = 1'b1,
  parameter  logic [DBIT-1:0] HDR_BASE     = DBIT'(HDR_BASE_DEF),
  parameter  int unsigned     HOLD_TIMEOUT = 1023,
  localparam int unsigned     IW           = (N > 1) ? clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DBIT-1:0] req_data,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic [IW-1:0]     grant_id,
  output logic              timeout_err
);

  localparam int unsigned CW = clog2(HOLD_TIMEOUT + 1);

  arb_state_t      state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   grant_id_q;
  logic [CW-1:0]   hold_cnt_q;
  logic            last_flag_q;
  logic [N-1:0]    req_ready_q;
  logic            tx_start_q;
  logic [DBIT-1:0] tx_din_q;
  logic            busy_q;
  logic            timeout_err_q;

  logic            pick_found_c;
  logic [IW-1:0]   pick_idx_c;
  logic [IW-1:0]   rr_next_d;
  logic [CW:0]     hold_inc_d;
  logic [IW-1:0]   sel_idx_d;
  logic [DBIT-1:0] send_data_d;
  logic            send_last_d;
  logic [N-1:0]    send_ready_d;
  logic            owner_valid_d;

  logic [DBIT-1:0] data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DBIT +: DBIT];
  end

  rr_picker #(.N(N)) u_picker (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .found_c_o   (pick_found_c),
    .index_c_o   (pick_idx_c)
  );

  // In IDLE the byte comes from the requester being granted; otherwise from the owner.
  always_comb begin
    rr_next_d     = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + IW'(1);
    hold_inc_d    = (CW+1)'(hold_cnt_q) + (CW+1)'(1);
    sel_idx_d     = (state_q == IDLE) ? pick_idx_c : grant_id_q;
    send_data_d   = data_arr[sel_idx_d];
    send_last_d   = req_last[sel_idx_d];
    send_ready_d  = N'(1) << sel_idx_d;
    owner_valid_d = req_valid[grant_id_q];
  end

  // Outputs are registered on the edge entering the state they belong to, so
  // tx_start/req_ready are high exactly during the HDR and SEND cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      hold_cnt_q    <= '0;
      last_flag_q   <= 1'b0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_din_q      <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_din_q      <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found_c) begin
            grant_id_q <= pick_idx_c;
            busy_q     <= 1'b1;
            tx_start_q <= 1'b1;
            if (HDR_EN) begin
              state_q     <= HDR;
              tx_din_q    <= HDR_BASE | DBIT'(pick_idx_c);
              last_flag_q <= 1'b0;
            end else begin
              state_q     <= SEND;
              tx_din_q    <= send_data_d;
              req_ready_q <= send_ready_d;
              last_flag_q <= send_last_d;
            end
          end
        end
        HDR:  state_q <= WAIT;
        SEND: state_q <= WAIT;
        WAIT: begin
          if (tx_done_tick) begin
            if (last_flag_q) begin
              rr_ptr_q <= rr_next_d;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else if (owner_valid_d) begin
              state_q     <= SEND;
              tx_start_q  <= 1'b1;
              tx_din_q    <= send_data_d;
              req_ready_q <= send_ready_d;
              last_flag_q <= send_last_d;
            end else begin
              hold_cnt_q <= '0;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (owner_valid_d) begin
            state_q     <= SEND;
            tx_start_q  <= 1'b1;
            tx_din_q    <= send_data_d;
            req_ready_q <= send_ready_d;
            last_flag_q <= send_last_d;
          end else begin
            hold_cnt_q <= hold_inc_d[CW-1:0];
            if (hold_inc_d == (CW+1)'(HOLD_TIMEOUT)) begin
              timeout_err_q <= 1'b1;
              rr_ptr_q      <= rr_next_d;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_din      = tx_din_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters and a uart_tx stand-in
// against a packet-level round-robin model of the expected character stream.
module tb_uart_tx_arbiter;

  localparam int unsigned NA = 4;
  localparam int unsigned NB = 3;
  localparam int unsigned HT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: N=4, headers on
  logic           a_reset;
  logic [NA-1:0]  a_req_valid, a_req_last, a_req_ready;
  logic [NA*8-1:0] a_req_data;
  logic           a_tx_start, a_tx_done, a_busy, a_timeout_err;
  logic [7:0]     a_tx_din;
  logic [1:0]     a_grant_id;

  // DUT B: N=3, headers off
  logic           b_reset;
  logic [NB-1:0]  b_req_valid, b_req_last, b_req_ready;
  logic [NB*8-1:0] b_req_data;
  logic           b_tx_start, b_tx_done, b_busy, b_timeout_err;
  logic [7:0]     b_tx_din;
  logic [1:0]     b_grant_id;

  uart_tx_arbiter #(.N(NA), .DBIT(8), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .HOLD_TIMEOUT(HT)) dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_last(a_req_last), .req_ready(a_req_ready), .tx_start(a_tx_start), .tx_din(a_tx_din),
    .tx_done_tick(a_tx_done), .busy(a_busy), .grant_id(a_grant_id), .timeout_err(a_timeout_err)
  );

  uart_tx_arbiter #(.N(NB), .DBIT(8), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .HOLD_TIMEOUT(HT)) dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_last(b_req_last), .req_ready(b_req_ready), .tx_start(b_tx_start), .tx_din(b_tx_din),
    .tx_done_tick(b_tx_done), .busy(b_busy), .grant_id(b_grant_id), .timeout_err(b_timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Requester byte queues for DUT A
  logic [7:0] rq_data [NA][16];
  logic       rq_last [NA][16];
  int         rq_len  [NA];
  int         rq_pos  [NA];

  int         m_rr;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  bit outstanding;
  int tx_cnt;
  int step_no;
  int last_tick_step;
  bit tick_final_pending;
  int to_pulses;
  int to_delta;
  int ready_cnt [NA];

  function automatic void clear_reqs();
    for (int i = 0; i < NA; i++) begin
      rq_len[i] = 0;
      rq_pos[i] = 0;
    end
  endfunction

  function automatic void add_byte(input int r, input logic [7:0] d, input logic l);
    rq_data[r][rq_len[r]] = d;
    rq_last[r][rq_len[r]] = l;
    rq_len[r]++;
  endfunction

  function automatic void drive_a();
    for (int i = 0; i < NA; i++) begin
      if (rq_pos[i] < rq_len[i]) begin
        a_req_valid[i]       = 1'b1;
        a_req_data[i*8 +: 8] = rq_data[i][rq_pos[i]];
        a_req_last[i]        = rq_last[i][rq_pos[i]];
      end else begin
        a_req_valid[i]       = 1'b0;
        a_req_data[i*8 +: 8] = 8'h00;
        a_req_last[i]        = 1'b0;
      end
    end
  endfunction

  // Packet-level model: serve the first non-empty requester from the pointer,
  // emit its header then bytes until last (or until it runs dry), advance pointer.
  function automatic void model_build();
    int  pos [NA];
    int  owner;
    bit  any;
    exp_q.delete();
    for (int i = 0; i < NA; i++) pos[i] = rq_pos[i];
    for (int guard = 0; guard < 64; guard++) begin
      any   = 1'b0;
      owner = 0;
      for (int k = 0; k < NA; k++) begin
        int idx;
        idx = (m_rr + k) % NA;
        if (!any && pos[idx] < rq_len[idx]) begin
          any   = 1'b1;
          owner = idx;
        end
      end
      if (!any) break;
      exp_q.push_back(8'hA0 | 8'(owner));
      for (int b = 0; b < 16; b++) begin
        logic l;
        exp_q.push_back(rq_data[owner][pos[owner]]);
        l = rq_last[owner][pos[owner]];
        pos[owner]++;
        if (l || pos[owner] >= rq_len[owner]) break;
      end
      m_rr = (owner + 1) % NA;
    end
  endfunction

  function automatic void begin_scenario();
    got_q.delete();
    to_pulses = 0;
    to_delta  = 0;
    tick_final_pending = 1'b0;
    for (int i = 0; i < NA; i++) ready_cnt[i] = 0;
  endfunction

  // One clock of DUT A: sample, emulate uart_tx, update requesters.
  task automatic step_a();
    @(posedge clk); #1;
    step_no++;
    if (tick_final_pending) begin
      n_cmp++;
      if (a_busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_drop: busy=%b expected 0 one cycle after final tx_done_tick", a_busy);
      end
      tick_final_pending = 1'b0;
    end
    if (a_tx_start === 1'b1) begin
      n_cmp++;
      if (outstanding) begin
        n_err++;
        $display("FAIL one_outstanding: tx_start=1 while previous character busy, expected 0");
      end
      got_q.push_back(a_tx_din);
      outstanding = 1'b1;
      tx_cnt = $urandom_range(2, 6);
    end
    if (a_req_ready !== '0) begin
      n_cmp++;
      if ($countones(a_req_ready) != 1 || a_tx_start !== 1'b1) begin
        n_err++;
        $display("FAIL ready_shape: req_ready=%b tx_start=%b expected one-hot with tx_start=1",
                 a_req_ready, a_tx_start);
      end
      for (int i = 0; i < NA; i++) begin
        if (a_req_ready[i]) begin
          ready_cnt[i]++;
          if (rq_pos[i] < rq_len[i]) rq_pos[i]++;
        end
      end
    end
    if (a_timeout_err === 1'b1) begin
      to_pulses++;
      to_delta = step_no - last_tick_step;
    end
    a_tx_done = 1'b0;
    if (outstanding && a_tx_start !== 1'b1) begin
      tx_cnt--;
      if (tx_cnt <= 0) begin
        a_tx_done      = 1'b1;
        outstanding    = 1'b0;
        last_tick_step = step_no;
        if (got_q.size() == exp_q.size()) tick_final_pending = 1'b1;
      end
    end
    drive_a();
  endtask

  task automatic run_a(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      step_a();
      if (got_q.size() >= exp_q.size() && !outstanding && a_tx_done == 1'b0 && a_busy === 1'b0)
        done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s run_timeout: got %0d chars, expected %0d before budget", name, got_q.size(), exp_q.size());
    end
    repeat (4) step_a();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s stream_len: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s stream[%0d]: tx_din=%h expected %h", name, i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < NA; i++) begin
      n_cmp++;
      if (rq_pos[i] != rq_len[i]) begin
        n_err++;
        $display("FAIL %s drained[%0d]: consumed %0d expected %0d", name, i, rq_pos[i], rq_len[i]);
      end
    end
  endtask

  task automatic reset_a();
    a_reset   = 1'b1;
    a_tx_done = 1'b0;
    clear_reqs();
    drive_a();
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0;
    outstanding = 1'b0;
    tick_final_pending = 1'b0;
    m_rr = 0;
  endtask

  task automatic check_a_zero(input string name);
    n_cmp++;
    if (a_tx_start !== 1'b0 || a_req_ready !== 4'b0 || a_busy !== 1'b0 ||
        a_timeout_err !== 1'b0 || a_tx_din !== 8'h00 || a_grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL %s: start=%b ready=%b busy=%b to=%b din=%h gid=%0d expected all 0",
               name, a_tx_start, a_req_ready, a_busy, a_timeout_err, a_tx_din, a_grant_id);
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1;
    a_tx_done = 1'b0;
    clear_reqs();
    add_byte(1, 8'h77, 1'b1);
    drive_a();
    repeat (2) @(posedge clk);
    #1;
    check_a_zero("reset_hold");
    clear_reqs();
    drive_a();
    a_reset = 1'b0;
    @(posedge clk); #1;
    check_a_zero("reset_release");
    outstanding = 1'b0;
    m_rr = 0;
  endtask

  task automatic test_single_packet();
    reset_a();
    add_byte(2, 8'h55, 1'b0);
    add_byte(2, 8'h33, 1'b1);
    begin_scenario();
    model_build();
    drive_a();
    run_a("single", 300);
    n_cmp++;
    if (ready_cnt[2] != 2 || ready_cnt[0] != 0 || ready_cnt[1] != 0 || ready_cnt[3] != 0) begin
      n_err++;
      $display("FAIL single ready_pulses: counts %0d/%0d/%0d/%0d expected 0/0/2/0",
               ready_cnt[0], ready_cnt[1], ready_cnt[2], ready_cnt[3]);
    end
  endtask

  task automatic test_rr_after_single();
    for (int i = 0; i < NA; i++) add_byte(i, 8'(8'h10 + i), 1'b1);
    begin_scenario();
    model_build();
    drive_a();
    run_a("rr_after_single", 400);
    n_cmp++;
    if (got_q.size() == 0 || got_q[0] !== 8'hA3) begin
      n_err++;
      $display("FAIL rr_after_single first_hdr: got %h expected a3", got_q.size() ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_rr_fairness();
    reset_a();
    add_byte(0, 8'hC0, 1'b1);
    add_byte(0, 8'hC4, 1'b1);
    add_byte(1, 8'hC1, 1'b1);
    add_byte(2, 8'hC2, 1'b1);
    add_byte(3, 8'hC3, 1'b1);
    begin_scenario();
    model_build();
    drive_a();
    run_a("fairness", 500);
  endtask

  task automatic test_packet_hold();
    reset_a();
    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h22, 1'b0);
    add_byte(0, 8'h33, 1'b1);
    add_byte(1, 8'h44, 1'b1);
    begin_scenario();
    model_build();
    drive_a();
    run_a("packet_hold", 400);
  endtask

  task automatic test_timeout();
    reset_a();
    add_byte(1, 8'h5A, 1'b0);
    add_byte(2, 8'h6B, 1'b1);
    begin_scenario();
    model_build();
    drive_a();
    run_a("timeout", 400);
    n_cmp++;
    if (to_pulses != 1) begin
      n_err++;
      $display("FAIL timeout_pulses: saw %0d cycles of timeout_err expected 1", to_pulses);
    end
    n_cmp++;
    if (to_delta != HT + 1) begin
      n_err++;
      $display("FAIL timeout_latency: %0d cycles after tx_done_tick expected %0d", to_delta, HT + 1);
    end
  endtask

  task automatic test_random_packets();
    for (int round = 0; round < 4; round++) begin
      int total;
      clear_reqs();
      total = 0;
      for (int i = 0; i < NA; i++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
          total += len;
        end
      end
      if (total == 0) add_byte(int'($urandom_range(0, NA - 1)), 8'($urandom), 1'b1);
      begin_scenario();
      model_build();
      drive_a();
      run_a($sformatf("random%0d", round), 2000);
      n_cmp++;
      if (to_pulses != 0) begin
        n_err++;
        $display("FAIL random%0d no_timeout: timeout_err seen %0d times expected 0", round, to_pulses);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    int starts;
    reset_a();
    add_byte(3, 8'h9A, 1'b0);
    add_byte(3, 8'h9B, 1'b1);
    begin_scenario();
    model_build();
    drive_a();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step_a();
      if (got_q.size() > 0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_wait hdr_seen: no tx_start within 10 cycles, expected header");
    end
    step_a();
    a_reset   = 1'b1;
    a_tx_done = 1'b0;
    @(posedge clk); #1;
    check_a_zero("mid_wait_reset");
    a_reset = 1'b0;
    clear_reqs();
    drive_a();
    outstanding = 1'b0;
    tick_final_pending = 1'b0;
    m_rr = 0;
    a_tx_done = 1'b1;
    @(posedge clk); #1;
    a_tx_done = 1'b0;
    starts = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_tx_start !== 1'b0 || a_busy !== 1'b0) starts++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (starts != 0) begin
      n_err++;
      $display("FAIL stray_tick: %0d cycles with tx_start/busy after stray tick, expected 0", starts);
    end
  endtask

  task automatic test_hdr_off_wrap();
    int extra;
    b_reset = 1'b1;
    b_req_valid = '0; b_req_data = '0; b_req_last = '0; b_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b_reset = 1'b0;
    b_req_valid = 3'b100;
    b_req_data  = {8'h5C, 8'h00, 8'h00};
    b_req_last  = 3'b100;
    @(posedge clk); #1;
    n_cmp++;
    if (b_tx_start !== 1'b1 || b_tx_din !== 8'h5C || b_req_ready !== 3'b100 || b_grant_id !== 2'd2) begin
      n_err++;
      $display("FAIL b_first: start=%b din=%h ready=%b gid=%0d expected 1/5c/100/2",
               b_tx_start, b_tx_din, b_req_ready, b_grant_id);
    end
    b_req_valid = 3'b011;
    b_req_data  = {8'h00, 8'h7E, 8'hC3};
    b_req_last  = 3'b011;
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b_tx_start !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL b_wait_quiet: %0d tx_start pulses before tx_done_tick expected 0", extra);
    end
    b_tx_done = 1'b1;
    @(posedge clk); #1;
    b_tx_done = 1'b0;
    n_cmp++;
    if (b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b_idle_after_last: busy=%b expected 0", b_busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (b_tx_start !== 1'b1 || b_tx_din !== 8'hC3 || b_req_ready !== 3'b001 || b_grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL b_wrap: start=%b din=%h ready=%b gid=%0d expected 1/c3/001/0",
               b_tx_start, b_tx_din, b_req_ready, b_grant_id);
    end
    b_req_valid = 3'b010;
    b_req_last  = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    b_tx_done = 1'b1;
    @(posedge clk); #1;
    b_tx_done = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_tx_start !== 1'b1 || b_tx_din !== 8'h7E || b_req_ready !== 3'b010 || b_grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL b_next: start=%b din=%h ready=%b gid=%0d expected 1/7e/010/1",
               b_tx_start, b_tx_din, b_req_ready, b_grant_id);
    end
    b_req_valid = 3'b000;
    b_req_last  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    b_tx_done = 1'b1;
    @(posedge clk); #1;
    b_tx_done = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_busy !== 1'b0 || b_tx_start !== 1'b0 || b_timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL b_end: busy=%b start=%b to=%b expected 0/0/0", b_busy, b_tx_start, b_timeout_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; a_req_valid = '0; a_req_data = '0; a_req_last = '0; a_tx_done = 1'b0;
    b_reset = 1'b1; b_req_valid = '0; b_req_data = '0; b_req_last = '0; b_tx_done = 1'b0;
    outstanding = 1'b0; tx_cnt = 0; step_no = 0; last_tick_step = 0; m_rr = 0;
    clear_reqs();
    begin_scenario();
    test_reset();
    test_single_packet();
    test_rr_after_single();
    test_rr_fairness();
    test_packet_hold();
    test_timeout();
    test_random_packets();
    test_reset_mid_wait();
    test_hdr_off_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
